// File: rtl/pipelined_mult_hs_if.sv
// Operand/result handshake bundle for pipelined_mult_hs.
// Tag signals exist only when PMULT_TAG_EN is defined.
interface pipelined_mult_hs_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 sgn;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   pdt;
`ifdef PMULT_TAG_EN
  logic [TAG_W-1:0]     in_tag;
  logic [TAG_W-1:0]     out_tag;
`endif

  if (WIDTH < 2) begin : g_bad_width
    $error("pipelined_mult_hs_if: WIDTH must be at least 2");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("pipelined_mult_hs_if: TAG_W must be at least 1");
  end

`ifdef PMULT_TAG_EN
  modport master (
    output in_valid, a, b, sgn, in_tag, out_ready,
    input  in_ready, out_valid, pdt, out_tag
  );
  modport slave (
    input  in_valid, a, b, sgn, in_tag, out_ready,
    output in_ready, out_valid, pdt, out_tag
  );
`else
  modport master (
    output in_valid, a, b, sgn, out_ready,
    input  in_ready, out_valid, pdt
  );
  modport slave (
    input  in_valid, a, b, sgn, out_ready,
    output in_ready, out_valid, pdt
  );
`endif

endinterface

// File: rtl/pipelined_mult_hs.sv
// Handshaked WIDTH x WIDTH multiplier: operand register plus STAGES product registers.
// Optional beat tagging is enabled with the PMULT_TAG_EN macro.
module pipelined_mult_hs #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipelined_mult_hs_if.slave            bus,
  output logic [$clog2(STAGES+2)-1:0]   busy_cnt
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(STAGES + 2);

  if (WIDTH < 2) begin : g_bad_width
    $error("pipelined_mult_hs: WIDTH must be at least 2");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("pipelined_mult_hs: STAGES must be at least 1");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("pipelined_mult_hs: TAG_W must be at least 1");
  end

  logic              stall;
  logic              accept;
  logic              retire;
  logic              out_v;

  logic              op_v;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              op_sgn;

  logic [STAGES-1:0] pv;
  logic [PW-1:0]     pd [STAGES];

  logic [PW-1:0]     ext_a;
  logic [PW-1:0]     ext_b;
  logic [PW-1:0]     mult;

  // A full stall freezes every register, bubbles included.
  assign out_v        = pv[STAGES-1];
  assign stall        = out_v & ~bus.out_ready;
  assign accept       = bus.in_valid & ~stall;
  assign retire       = out_v & bus.out_ready;

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_v;
  assign bus.pdt       = pd[STAGES-1];

  // The low 2*WIDTH bits of the extended product are exact for both modes.
  always_comb begin
    ext_a = op_sgn ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    ext_b = op_sgn ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    mult  = ext_a * ext_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_v   <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_sgn <= 1'b0;
    end else if (!stall) begin
      op_v   <= bus.in_valid;
      op_a   <= bus.a;
      op_b   <= bus.b;
      op_sgn <= bus.sgn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        pd[i] <= '0;
      end
    end else if (!stall) begin
      pv[0] <= op_v;
      pd[0] <= mult;
      for (int unsigned i = 1; i < STAGES; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else begin
      case ({accept, retire})
        2'b10:   busy_cnt <= busy_cnt + CW'(1);
        2'b01:   busy_cnt <= busy_cnt - CW'(1);
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

`ifdef PMULT_TAG_EN
  logic [TAG_W-1:0] op_tag;
  logic [TAG_W-1:0] pt [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_tag <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        pt[i] <= '0;
      end
    end else if (!stall) begin
      op_tag <= bus.in_tag;
      pt[0]  <= op_tag;
      for (int unsigned i = 1; i < STAGES; i++) begin
        pt[i] <= pt[i-1];
      end
    end
  end

  assign bus.out_tag = pt[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_mult_hs.sv
// Self-checking bench for pipelined_mult_hs against a beat-queue reference model.
module tb_pipelined_mult_hs;

  localparam int unsigned W  = 8;
  localparam int unsigned S  = 4;
  localparam int unsigned T  = 4;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(S + 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] busy_cnt;

  always #5 clk = ~clk;

  pipelined_mult_hs_if #(.WIDTH(W), .TAG_W(T)) bus ();

  pipelined_mult_hs #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .busy_cnt (busy_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Each in-flight beat carries its expected result and the number of
  // non-stalled edges still needed before it shows at the output.
  typedef struct {
    logic [PW-1:0] p;
    logic [T-1:0]  tag;
    int            cnt;
  } beat_t;

  beat_t q[$];
  logic [T-1:0] drv_tag = '0;

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    longint sx, sy, r;
    logic [PW-1:0] res;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[W-1]) sx = sx - (longint'(1) << W);
    if (s && y[W-1]) sy = sy - (longint'(1) << W);
    r = sx * sy;
    res = r[PW-1:0];
    return res;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit    m_stall;
    beat_t nb;
    if (!rst_n) begin
      q.delete();
    end else begin
      m_stall = (q.size() > 0) && (q[0].cnt == 0) && !bus.out_ready;
      if (!m_stall) begin
        if (q.size() > 0 && q[0].cnt == 0) void'(q.pop_front());
        foreach (q[i]) if (q[i].cnt > 0) q[i].cnt = q[i].cnt - 1;
        if (bus.in_valid) begin
          nb.p   = ref_mul(bus.a, bus.b, bus.sgn);
          nb.tag = drv_tag;
          nb.cnt = S;
          q.push_back(nb);
        end
      end
    end
  end

`ifdef PMULT_TAG_EN
  assign bus.in_tag = drv_tag;
`endif

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sgn       = 1'b0;
    bus.out_ready = 1'b1;
    drv_tag       = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.pdt !== '0) begin n_fail++; $display("FAIL reset_pdt: got %h want 0", bus.pdt); end
    n_checks++;
    if (busy_cnt !== '0) begin n_fail++; $display("FAIL reset_busy: got %0d want 0", busy_cnt); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
`ifdef PMULT_TAG_EN
    n_checks++;
    if (bus.out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", bus.out_tag); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int lat;
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.sgn = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (busy_cnt !== CW'(1)) begin n_fail++; $display("FAIL single_busy_one: got %0d want 1", busy_cnt); end
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 5) begin n_fail++; $display("FAIL single_latency: got %0d want 5", lat); end
    n_checks++;
    if (bus.pdt !== 16'hFE01) begin n_fail++; $display("FAIL single_pdt: got %h want fe01", bus.pdt); end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_out_drop: got %b want 0", bus.out_valid); end
    n_checks++;
    if (busy_cnt !== '0) begin n_fail++; $display("FAIL single_busy_zero: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_signed_modes();
    logic [W-1:0]  va[3];
    logic [W-1:0]  vb[3];
    logic          vs[3];
    logic [PW-1:0] want[3];
    logic [PW-1:0] got[3];
    int            n;
    va[0] = 8'h80; vb[0] = 8'h7F; vs[0] = 1'b1; want[0] = 16'hC080;
    va[1] = 8'hFF; vb[1] = 8'hFF; vs[1] = 1'b1; want[1] = 16'h0001;
    va[2] = 8'hFF; vb[2] = 8'hFF; vs[2] = 1'b0; want[2] = 16'hFE01;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.a = va[k]; bus.b = vb[k]; bus.sgn = vs[k]; bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid === 1'b1 && n < 3) begin got[n] = bus.pdt; n++; end
      @(negedge clk);
    end
    n_checks++;
    if (n != 3) begin n_fail++; $display("FAIL signed_count: got %0d want 3", n); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= n || got[k] !== want[k]) begin
        n_fail++; $display("FAIL signed_pdt%0d: got %h want %h", k, got[k], want[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int got, first_c, last_c;
    logic [PW-1:0] expv;
    got = 0; first_c = -1; last_c = -1;
    bus.out_ready = 1'b1; bus.sgn = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c < 20) begin
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c%0d: got %b want 1", c, bus.in_ready); end
      end
      if (bus.out_valid === 1'b1) begin
        expv = PW'(got * (got + 1));
        n_checks++;
        if (bus.pdt !== expv) begin n_fail++; $display("FAIL b2b_pdt%0d: got %h want %h", got, bus.pdt, expv); end
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (c < 20) begin
        bus.a = W'(c); bus.b = W'(c + 1); bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    n_checks++;
    if (got != 20) begin n_fail++; $display("FAIL b2b_count: got %0d want 20", got); end
    n_checks++;
    if (last_c - first_c + 1 != 20) begin
      n_fail++; $display("FAIL b2b_contiguous: got span %0d want 20", last_c - first_c + 1);
    end
  endtask

  task automatic test_stall();
    logic [PW-1:0] first_p;
    logic          exp_ov;
    int            n_ret;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.a = W'($urandom); bus.b = W'($urandom); bus.sgn = 1'($urandom); bus.in_valid = 1'b1;
      if (k == 0) first_p = ref_mul(bus.a, bus.b, bus.sgn);
    end
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid c%0d: got %b want 1", c, bus.out_valid); end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c%0d: got %b want 0", c, bus.in_ready); end
      n_checks++;
      if (busy_cnt !== CW'(5)) begin n_fail++; $display("FAIL stall_busy c%0d: got %0d want 5", c, busy_cnt); end
      n_checks++;
      if (bus.pdt !== first_p) begin n_fail++; $display("FAIL stall_pdt c%0d: got %h want %h", c, bus.pdt, first_p); end
      if (c == 0) begin
        bus.a = W'($urandom); bus.b = W'($urandom); bus.sgn = 1'($urandom); bus.in_valid = 1'b1;
      end
      if (c < 3) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_ret = 1;
    for (int c = 0; c < 14; c++) begin
      exp_ov = (q.size() > 0) && (q[0].cnt == 0);
      n_checks++;
      if (bus.out_valid !== exp_ov) begin n_fail++; $display("FAIL drain_out_valid c%0d: got %b want %b", c, bus.out_valid, exp_ov); end
      n_checks++;
      if (busy_cnt !== CW'(q.size())) begin n_fail++; $display("FAIL drain_busy c%0d: got %0d want %0d", c, busy_cnt, q.size()); end
      if (exp_ov) begin
        n_checks++;
        if (bus.pdt !== q[0].p) begin n_fail++; $display("FAIL drain_pdt c%0d: got %h want %h", c, bus.pdt, q[0].p); end
      end
      if (bus.out_valid === 1'b1) n_ret++;
      @(negedge clk);
    end
    n_checks++;
    if (n_ret != 6) begin n_fail++; $display("FAIL stall_total: got %0d want 6", n_ret); end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.a = W'($urandom_range(1, 255)); bus.b = W'($urandom_range(1, 255)); bus.sgn = 1'b0; bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (busy_cnt !== CW'(3)) begin n_fail++; $display("FAIL midrst_pre_busy: got %0d want 3", busy_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.pdt !== '0) begin n_fail++; $display("FAIL midrst_pdt: got %h want 0", bus.pdt); end
    n_checks++;
    if (busy_cnt !== '0) begin n_fail++; $display("FAIL midrst_busy: got %0d want 0", busy_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale c%0d: got %b want 0", c, bus.out_valid); end
    end
    n_checks++;
    if (busy_cnt !== '0) begin n_fail++; $display("FAIL midrst_post_busy: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_random_flow();
    logic exp_ov, exp_rdy, will_acc;
    will_acc = 1'b0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 330; c++) begin
      @(negedge clk);
      exp_ov  = (q.size() > 0) && (q[0].cnt == 0);
      exp_rdy = !(exp_ov && !bus.out_ready);
      n_checks++;
      if (bus.out_valid !== exp_ov) begin n_fail++; $display("FAIL rand_out_valid c%0d: got %b want %b", c, bus.out_valid, exp_ov); end
      n_checks++;
      if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready c%0d: got %b want %b", c, bus.in_ready, exp_rdy); end
      n_checks++;
      if (busy_cnt !== CW'(q.size())) begin n_fail++; $display("FAIL rand_busy c%0d: got %0d want %0d", c, busy_cnt, q.size()); end
      if (exp_ov) begin
        n_checks++;
        if (bus.pdt !== q[0].p) begin n_fail++; $display("FAIL rand_pdt c%0d: got %h want %h", c, bus.pdt, q[0].p); end
`ifdef PMULT_TAG_EN
        n_checks++;
        if (bus.out_tag !== q[0].tag) begin n_fail++; $display("FAIL rand_tag c%0d: got %h want %h", c, bus.out_tag, q[0].tag); end
`endif
      end
      if (c < 300) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        if (!bus.in_valid || will_acc) begin
          bus.in_valid = ($urandom_range(0, 3) != 0);
          bus.a   = W'($urandom);
          bus.b   = W'($urandom);
          bus.sgn = 1'($urandom);
          if (bus.in_valid) drv_tag = drv_tag + T'(1);
        end
      end else begin
        bus.out_ready = 1'b1;
        if (will_acc) bus.in_valid = 1'b0;
      end
      #1 will_acc = bus.in_valid && bus.in_ready;
    end
    n_checks++;
    if (q.size() != 0 || busy_cnt !== '0) begin
      n_fail++; $display("FAIL rand_drained: got busy %0d want 0 (model %0d)", busy_cnt, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed_modes();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random_flow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
